// File: rtl/pipeline_pkg.sv
// Constants shared by the D-stage hazard controller and the MDU busy timer.
package pipeline_pkg;

    localparam int AW       = 5;
    localparam int TW       = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int CNT_W    = 4;
    localparam int PERF_W   = 32;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy countdown: md_busy while the counter is non-zero,
// a one-cycle md_done after a natural 1->0 transition, sticky md_err on overlap.
module md_busy_timer #(
    parameter int MULT_CYC = pipeline_pkg::MULT_CYC,
    parameter int DIV_CYC  = pipeline_pkg::DIV_CYC,
    parameter int CNT_W    = pipeline_pkg::CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy,
    output logic md_done,
    output logic md_err
);

    // md_start is a single-cycle pulse with no back-pressure; a start while
    // busy is accepted anyway (the restart wins) and flagged in md_err.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = err_q;
        if (md_start) begin
            cnt_d = md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            if (cnt_q != '0) begin
                err_d = 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign md_busy = (cnt_q != '0);
    assign md_done = done_q;
    assign md_err  = err_q;

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// D-stage hazard controller: Tuse/Tnew stall, E/M forwarding selects,
// MDU busy interlock and a saturating stall-cycle counter.
module hazard_ctrl_mdu #(
    parameter int AW       = pipeline_pkg::AW,
    parameter int TW       = pipeline_pkg::TW,
    parameter int MULT_CYC = pipeline_pkg::MULT_CYC,
    parameter int DIV_CYC  = pipeline_pkg::DIV_CYC,
    parameter int CNT_W    = pipeline_pkg::CNT_W,
    parameter int PERF_W   = pipeline_pkg::PERF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     D_rs,
    input  logic [AW-1:0]     D_rt,
    input  logic [TW-1:0]     T_use_rs,
    input  logic [TW-1:0]     T_use_rt,
    input  logic              D_md_use,
    input  logic [AW-1:0]     E_A3,
    input  logic [TW-1:0]     E_T_new,
    input  logic [AW-1:0]     M_A3,
    input  logic [TW-1:0]     M_T_new,
    input  logic              E_md_start,
    input  logic              E_md_div,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              md_busy,
    output logic              md_done,
    output logic              md_err,
    output logic [PERF_W-1:0] stall_cnt
);

    import pipeline_pkg::FWD_RF;
    import pipeline_pkg::FWD_E;
    import pipeline_pkg::FWD_M;

    logic              rs_nz, rt_nz;
    logic              hit_e_rs, hit_m_rs, hit_e_rt, hit_m_rt;
    logic              md_stall;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .md_start (E_md_start),
        .md_div   (E_md_div),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .md_err   (md_err)
    );

    always_comb begin
        rs_nz    = (D_rs != '0);
        rt_nz    = (D_rt != '0);
        // A producer stalls D only if its value arrives later than D needs it.
        hit_e_rs = (E_A3 == D_rs) && rs_nz && (E_T_new > T_use_rs);
        hit_m_rs = (M_A3 == D_rs) && rs_nz && (M_T_new > T_use_rs);
        hit_e_rt = (E_A3 == D_rt) && rt_nz && (E_T_new > T_use_rt);
        hit_m_rt = (M_A3 == D_rt) && rt_nz && (M_T_new > T_use_rt);
        md_stall = D_md_use && (md_busy || E_md_start);
        stall    = hit_e_rs || hit_m_rs || hit_e_rt || hit_m_rt || md_stall;

        fwd_rs_sel = FWD_RF;
        if ((E_A3 == D_rs) && rs_nz && (E_T_new == '0)) begin
            fwd_rs_sel = FWD_E;
        end else if ((M_A3 == D_rs) && rs_nz && (M_T_new == '0)) begin
            fwd_rs_sel = FWD_M;
        end

        fwd_rt_sel = FWD_RF;
        if ((E_A3 == D_rt) && rt_nz && (E_T_new == '0)) begin
            fwd_rt_sel = FWD_E;
        end else if ((M_A3 == D_rt) && rt_nz && (M_T_new == '0)) begin
            fwd_rt_sel = FWD_M;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Directed bench for hazard_ctrl_mdu: combinational vector table plus
// hand-written MDU countdown, restart, reset-abort and saturation sequences.
module tb_hazard_ctrl_mdu;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    D_rs, D_rt, E_A3, M_A3;
  logic [1:0]    T_use_rs, T_use_rt, E_T_new, M_T_new;
  logic          D_md_use, E_md_start, E_md_div;
  logic          stall, md_busy, md_done, md_err;
  logic [1:0]    fwd_rs_sel, fwd_rt_sel;
  logic [PW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [4:0] rs, rt, ea3, ma3;
    logic [1:0] tus, tut, etn, mtn;
    logic       md_use;
    logic       exp_stall;
    logic [1:0] exp_frs, exp_frt;
  } vec_t;

  vec_t vecs[12];

  hazard_ctrl_mdu #(.PERF_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .T_use_rs   (T_use_rs),
    .T_use_rt   (T_use_rt),
    .D_md_use   (D_md_use),
    .E_A3       (E_A3),
    .E_T_new    (E_T_new),
    .M_A3       (M_A3),
    .M_T_new    (M_T_new),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; T_use_rs = 0; T_use_rt = 0; D_md_use = 0;
    E_A3 = 0; E_T_new = 0; M_A3 = 0; M_T_new = 0;
    E_md_start = 0; E_md_div = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] tus,
                              input logic [4:0] rt, input logic [1:0] tut,
                              input logic [4:0] ea3, input logic [1:0] etn,
                              input logic [4:0] ma3, input logic [1:0] mtn,
                              input logic md_use, input logic st,
                              input logic [1:0] frs, input logic [1:0] frt);
    vec_t v;
    v.rs = rs; v.tus = tus; v.rt = rt; v.tut = tut;
    v.ea3 = ea3; v.etn = etn; v.ma3 = ma3; v.mtn = mtn;
    v.md_use = md_use; v.exp_stall = st; v.exp_frs = frs; v.exp_frt = frt;
    return v;
  endfunction

  initial begin
    //                rs tus rt tut ea3 etn ma3 mtn md  stall frs frt
    vecs[0]  = mk(8,  0, 0,  0, 8,  2, 0,  0, 0, 1, 0, 0);
    vecs[1]  = mk(8,  0, 0,  0, 0,  0, 8,  1, 0, 1, 0, 0);
    vecs[2]  = mk(8,  0, 0,  0, 0,  0, 8,  0, 0, 0, 2, 0);
    vecs[3]  = mk(0,  0, 0,  0, 0,  2, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mk(0,  0, 5,  0, 5,  0, 5,  0, 0, 0, 0, 1);
    vecs[5]  = mk(3,  1, 0,  0, 3,  1, 0,  0, 0, 0, 0, 0);
    vecs[6]  = mk(0,  0, 7,  1, 0,  0, 7,  2, 0, 1, 0, 0);
    vecs[7]  = mk(9,  2, 0,  0, 9,  3, 0,  0, 0, 1, 0, 0);
    vecs[8]  = mk(4,  1, 4,  0, 4,  0, 4,  0, 0, 0, 1, 1);
    vecs[9]  = mk(0,  0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 0);
    vecs[10] = mk(31, 0, 0,  0, 0,  0, 31, 1, 0, 1, 0, 0);
    vecs[11] = mk(6,  0, 2,  3, 2,  0, 6,  0, 0, 0, 2, 1);

    do_reset();
    sample();
    chk("reset_busy", md_busy, 0);
    chk("reset_done", md_done, 0);
    chk("reset_err", md_err, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_stall", stall, 0);

    // Combinational stall / forwarding table.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      D_rs = vecs[i].rs; T_use_rs = vecs[i].tus;
      D_rt = vecs[i].rt; T_use_rt = vecs[i].tut;
      E_A3 = vecs[i].ea3; E_T_new = vecs[i].etn;
      M_A3 = vecs[i].ma3; M_T_new = vecs[i].mtn;
      D_md_use = vecs[i].md_use;
      sample();
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_fwd_rs", i), fwd_rs_sel, vecs[i].exp_frs);
      chk($sformatf("vec%0d_fwd_rt", i), fwd_rt_sel, vecs[i].exp_frt);
    end

    // Mult start in cycle 0 with an MDU consumer in D.
    do_reset();
    D_md_use = 1; E_md_start = 1; E_md_div = 0;
    sample();
    chk("mult_c0_stall", stall, 1);
    chk("mult_c0_busy", md_busy, 0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      E_md_start = 0;
      sample();
      chk($sformatf("mult_c%0d_busy", c), md_busy, 1);
      chk($sformatf("mult_c%0d_stall", c), stall, 1);
      chk($sformatf("mult_c%0d_done", c), md_done, 0);
    end
    next_cycle();
    sample();
    chk("mult_c6_busy", md_busy, 0);
    chk("mult_c6_done", md_done, 1);
    chk("mult_c6_stall", stall, 0);
    chk("mult_c6_stall_cnt", stall_cnt, 6);
    chk("mult_c6_err", md_err, 0);
    next_cycle();
    sample();
    chk("mult_c7_done", md_done, 0);

    // Div start, then a second div start in busy cycle 3: error and reload.
    do_reset();
    E_md_start = 1; E_md_div = 1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      E_md_start = (c == 3);
      sample();
      chk($sformatf("div_c%0d_busy", c), md_busy, 1);
    end
    for (int c = 4; c <= 13; c++) begin
      next_cycle();
      E_md_start = 0;
      sample();
      chk($sformatf("restart_c%0d_busy", c), md_busy, 1);
      chk($sformatf("restart_c%0d_done", c), md_done, 0);
      chk($sformatf("restart_c%0d_err", c), md_err, 1);
    end
    next_cycle();
    sample();
    chk("restart_c14_busy", md_busy, 0);
    chk("restart_c14_done", md_done, 1);
    chk("restart_c14_err_sticky", md_err, 1);

    // Restart on the cycle the counter is 1: the load wins, no md_done.
    do_reset();
    E_md_start = 1; E_md_div = 0;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      E_md_start = (c == 5);
    end
    for (int c = 6; c <= 10; c++) begin
      next_cycle();
      E_md_start = 0;
      sample();
      chk($sformatf("reload_c%0d_done", c), md_done, 0);
      chk($sformatf("reload_c%0d_busy", c), md_busy, 1);
    end
    next_cycle();
    sample();
    chk("reload_c11_done", md_done, 1);

    // Reset in the middle of a divide aborts it silently.
    do_reset();
    D_md_use = 1; E_md_start = 1; E_md_div = 1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      E_md_start = 0;
      if (c == 4) reset = 1'b0;
    end
    sample();
    chk("abort_c4_stall_cnt", stall_cnt, 4);
    chk("abort_c4_stall_in_reset", stall, 1);
    next_cycle();
    reset = 1'b1;
    D_md_use = 0;
    sample();
    chk("abort_c5_busy", md_busy, 0);
    chk("abort_c5_stall_cnt", stall_cnt, 0);
    for (int c = 6; c <= 15; c++) begin
      next_cycle();
      sample();
      chk($sformatf("abort_c%0d_done", c), md_done, 0);
    end

    // Hold a register hazard for 2^PW+3 cycles: counter saturates at 15.
    do_reset();
    D_rs = 12; E_A3 = 12; E_T_new = 1; T_use_rs = 0;
    for (int c = 1; c <= 14; c++) next_cycle();
    sample();
    chk("sat_before_full", stall_cnt, 14);
    next_cycle();
    sample();
    chk("sat_full", stall_cnt, 15);
    for (int c = 0; c < 4; c++) next_cycle();
    sample();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_stall", stall, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mdu.md
Name: hazard_ctrl_mdu

Overview:
- Parametrised hazard controller for the 5-stage pipeline (D/E/M/W).
- Generates the D-stage stall and the D-stage forwarding selects from Tuse/Tnew comparison.
- Owns the multiply/divide busy countdown internally; the external busy input of the previous generation is no longer used.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- AW, 5, register-address width.
- TW, 2, width of T_use/T_new fields.
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.
- CNT_W, 4, busy-counter width; must hold max(MULT_CYC, DIV_CYC).
- PERF_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- D_rs  in  AW  rs of the instruction in D.
- D_rt  in  AW  rt of the instruction in D.
- T_use_rs  in  TW  cycles until rs is consumed.
- T_use_rt  in  TW  cycles until rt is consumed.
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  AW  destination register in E (0 = none).
- E_T_new  in  TW  cycles until the E result is available.
- M_A3  in  AW  destination register in M.
- M_T_new  in  TW  cycles until the M result is available.
- E_md_start  in  1  E instruction starts the MDU this cycle.
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu.
- stall  out  1  freeze PC and F/D; bubble into E.
- fwd_rs_sel  out  2  0 = regfile/W path, 1 = from E, 2 = from M.
- fwd_rt_sel  out  2  same encoding as fwd_rs_sel, for rt.
- md_busy  out  1  MDU counter non-zero.
- md_done  out  1  one-cycle pulse when the counter reaches 0.
- md_err  out  1  sticky: a start arrived while busy.
- stall_cnt  out  PERF_W  number of cycles with stall=1.

Behaviour:
- Reset (reset==0 at a clk edge): busy counter=0, md_done=0, md_err=0, stall_cnt=0. Reset mid-count aborts the countdown with no md_done pulse. Combinational outputs follow their inputs during reset.
- Register-dependency stall, per source rs/rt and per stage S in {E,M}: hit = (S_A3==src) && (src!=0) && (S_T_new > T_use_src). Compare T values unsigned, TW bits.
- MDU stall: D_md_use && (md_busy || E_md_start).
- stall = OR of the four register hits and the MDU stall. Purely combinational, same cycle.
- Forwarding selects, computed per source:
  - 1 if E_A3==src, src!=0 and E_T_new==0.
  - else 2 if M_A3==src, src!=0 and M_T_new==0.
  - else 0.
  - E has priority over M.
  - Forwarding selects remain valid while stall=1; D discards them.
- Busy counter, updated each edge:
  - If E_md_start: load DIV_CYC if E_md_div, else MULT_CYC. If the counter is non-zero at that edge, also set md_err; the restart still takes effect.
  - Else if counter != 0: decrement by 1.
- md_busy = (counter != 0), registered-derived. md_busy rises the cycle after start and stays high exactly MULT_CYC/DIV_CYC cycles.
- md_done: registered, 1 for the single cycle after the counter transitions 1->0. Not asserted on restart or reset.
- stall_cnt: +1 on each edge where stall==1; saturates at all-ones with no wrap.
- Simultaneous start and counter reaching 1: the load wins and md_done is not pulsed.
- Register 0 never stalls and is never forwarded.

Decomposition:
- Shared package (pipeline_pkg): AW, TW, FWD_RF=0 / FWD_E=1 / FWD_M=2 encodings, MULT_CYC/DIV_CYC defaults. The MDU block imports the same constants.
- One natural sub-module, md_busy_timer: counter, md_busy, md_done, md_err.
- The top level holds the stall/forwarding comparison logic and stall_cnt.

Test Plan:
- E_A3=8, E_T_new=2, D_rs=8, T_use_rs=0 -> stall=1, fwd_rs_sel=0. Advance: M_A3=8, M_T_new=1 -> stall=1. Then M_T_new=0 -> stall=0, fwd_rs_sel=2.
- E_A3=0, E_T_new=2, D_rs=0 -> stall=0, fwd_rs_sel=0. Both E_A3 and M_A3 =5 with T_new=0, D_rt=5 -> fwd_rt_sel=1.
- E_md_start=1, E_md_div=0 at cycle 0 -> md_busy=1 for cycles 1..5, md_done=1 in cycle 6 only. D_md_use=1 during cycles 0..5 -> stall=1; cycle 6 -> stall=0.
- Div start, then reset low at cycle 4 -> md_busy=0 and stall_cnt=0 from cycle 5, no md_done. Second start at busy cycle 3 without reset -> md_err=1 sticky, counter reloads to DIV_CYC.
- Hold stall=1 for 2^PERF_W+3 cycles with PERF_W=4 -> stall_cnt=15 and stays 15.
